// File: rtl/iob_shift_reg_prog.sv
// Runtime-programmable delay line built on an external dual-port RAM used as a
// ring buffer of length D+1; each pushed sample reappears on data_o D pushes later.
module iob_shift_reg_prog #(
    parameter int DATA_W    = 21,
    parameter int N         = 32,
    parameter int ADDR_W    = $clog2(N),
    parameter int DEF_DELAY = N - 1
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_n_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] delay_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] level_o,
    output logic [ADDR_W-1:0] delay_o,
    output logic              ext_mem_clk_o,
    output logic              ext_mem_w_en_o,
    output logic [ADDR_W-1:0] ext_mem_w_addr_o,
    output logic [DATA_W-1:0] ext_mem_w_data_o,
    output logic              ext_mem_r_en_o,
    output logic [ADDR_W-1:0] ext_mem_r_addr_o,
    input  logic [DATA_W-1:0] ext_mem_r_data_i
);

    localparam logic [ADDR_W-1:0] MAX_D = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] RST_D = ADDR_W'(DEF_DELAY);
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

    // A zero delay cannot be realised by a read-after-write ring, so it becomes 1.
    function automatic logic [ADDR_W-1:0] clamp_delay(input logic [ADDR_W-1:0] d);
        if (d == '0) begin
            return ONE;
        end else if (d > MAX_D) begin
            return MAX_D;
        end else begin
            return d;
        end
    endfunction

    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [ADDR_W-1:0] level_q, level_d;
    logic [ADDR_W-1:0] delay_q, delay_d;
    logic              valid_q, valid_d;
    logic              push;
    logic              restart;
    logic [ADDR_W-1:0] wa_next;

    always_comb begin
        push    = en_i & cke_i & ~rst_i;
        restart = rst_i & cke_i;
        wa_next = (wa_q == delay_q) ? '0 : wa_q + ONE;

        wa_d    = wa_q;
        level_d = level_q;
        delay_d = delay_q;
        valid_d = valid_q;

        if (restart) begin
            wa_d    = '0;
            level_d = '0;
            valid_d = 1'b0;
            delay_d = clamp_delay(delay_i);
        end else if (push) begin
            wa_d    = wa_next;
            level_d = (level_q == delay_q) ? delay_q : level_q + ONE;
            if (level_q == delay_q) begin
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wa_q    <= '0;
            level_q <= '0;
            delay_q <= RST_D;
            valid_q <= 1'b0;
        end else begin
            wa_q    <= wa_d;
            level_q <= level_d;
            delay_q <= delay_d;
            valid_q <= valid_d;
        end
    end

    // The read slot is the oldest entry, always distinct from the write slot.
    assign ext_mem_clk_o    = clk_i;
    assign ext_mem_w_en_o   = push;
    assign ext_mem_r_en_o   = push;
    assign ext_mem_w_addr_o = wa_q;
    assign ext_mem_r_addr_o = wa_next;
    assign ext_mem_w_data_o = data_i;

    assign data_o  = valid_q ? ext_mem_r_data_i : '0;
    assign valid_o = valid_q;
    assign level_o = level_q;
    assign delay_o = delay_q;

endmodule

// File: tb/tb_iob_shift_reg_prog.sv
// Directed + randomized bench for iob_shift_reg_prog with a behavioural RAM and a
// sample-history reference model of the programmable delay line.
module tb_iob_shift_reg_prog;

    localparam int DW = 21;
    localparam int NN = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          cke_i, rst_i, en_i;
    logic [AW-1:0] delay_i;
    logic [DW-1:0] data_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic [AW-1:0] level_o, delay_o;
    logic          m_clk, w_en, r_en;
    logic [AW-1:0] w_addr, r_addr;
    logic [DW-1:0] w_data;
    logic [DW-1:0] r_data = '0;
    logic [DW-1:0] mem [NN];

    // second instance with N=20 for the upper clamp
    logic          rst20;
    logic [AW-1:0] dly20;
    logic [DW-1:0] zero20 = '0;
    logic [DW-1:0] d20_data, d20_wdata;
    logic          d20_valid, d20_clk, d20_wen, d20_ren;
    logic [AW-1:0] d20_level, d20_delay, d20_waddr, d20_raddr;

    always #5 clk = ~clk;

    iob_shift_reg_prog #(.DATA_W(DW), .N(NN)) u_dut (
        .clk_i(clk), .cke_i(cke_i), .arst_n_i(arst_n), .rst_i(rst_i),
        .delay_i(delay_i), .en_i(en_i), .data_i(data_i),
        .data_o(data_o), .valid_o(valid_o), .level_o(level_o), .delay_o(delay_o),
        .ext_mem_clk_o(m_clk), .ext_mem_w_en_o(w_en), .ext_mem_w_addr_o(w_addr),
        .ext_mem_w_data_o(w_data), .ext_mem_r_en_o(r_en), .ext_mem_r_addr_o(r_addr),
        .ext_mem_r_data_i(r_data)
    );

    iob_shift_reg_prog #(.DATA_W(DW), .N(20)) u_dut20 (
        .clk_i(clk), .cke_i(1'b1), .arst_n_i(arst_n), .rst_i(rst20),
        .delay_i(dly20), .en_i(1'b0), .data_i(zero20),
        .data_o(d20_data), .valid_o(d20_valid), .level_o(d20_level), .delay_o(d20_delay),
        .ext_mem_clk_o(d20_clk), .ext_mem_w_en_o(d20_wen), .ext_mem_w_addr_o(d20_waddr),
        .ext_mem_w_data_o(d20_wdata), .ext_mem_r_en_o(d20_ren), .ext_mem_r_addr_o(d20_raddr),
        .ext_mem_r_data_i(zero20)
    );

    // synchronous dual-port RAM, read data held while r_en is low
    always @(posedge m_clk) begin
        if (w_en) mem[w_addr] <= w_data;
        if (r_en) r_data <= mem[r_addr];
    end

    int passes = 0;
    int total  = 0;

    // reference model: active delay, pushes since restart, history of pushed samples
    int            d_m;
    int            cnt;
    logic [DW-1:0] hist[$];
    logic [DW-1:0] exp_data;
    logic          exp_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int clampd(input int d);
        if (d == 0) return 1;
        if (d > NN - 1) return NN - 1;
        return d;
    endfunction

    // one clock: drive at negedge, check strobes/addresses, clock, check state
    task automatic cyc(input logic c, input logic r, input logic e,
                       input logic [AW-1:0] d, input logic [DW-1:0] x);
        logic exp_push;
        int   p;
        cke_i = c; rst_i = r; en_i = e; delay_i = d; data_i = x;
        #1;
        exp_push = c & e & ~r;
        chk("w_en", 32'(w_en), 32'(exp_push));
        chk("r_en", 32'(r_en), 32'(exp_push));
        if (exp_push) begin
            chk("w_addr", 32'(w_addr), cnt % (d_m + 1));
            chk("r_addr", 32'(r_addr), (cnt + 1) % (d_m + 1));
            chk("w_data", 32'(w_data), 32'(x));
        end
        @(posedge clk);
        if (c && r) begin
            d_m = clampd(int'(d));
            cnt = 0;
            hist.delete();
            exp_valid = 1'b0;
            exp_data  = '0;
        end else if (exp_push) begin
            p = cnt;
            hist.push_back(x);
            if (p >= d_m) begin
                exp_valid = 1'b1;
                exp_data  = hist[p - d_m];
            end else if (!exp_valid) begin
                exp_data = '0;
            end
            cnt++;
        end
        #1;
        chk("data_o", 32'(data_o), 32'(exp_data));
        chk("valid_o", 32'(valid_o), 32'(exp_valid));
        chk("level_o", 32'(level_o), (cnt < d_m) ? cnt : d_m);
        chk("delay_o", 32'(delay_o), d_m);
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'($urandom);
    endfunction

    function automatic logic [AW-1:0] rnd_d();
        return AW'($urandom);
    endfunction

    initial begin
        for (int i = 0; i < NN; i++) mem[i] = DW'($urandom) | DW'(1);
        arst_n = 1'b0; cke_i = 1'b1; rst_i = 1'b0; en_i = 1'b0;
        delay_i = '0; data_i = '0; rst20 = 1'b0; dly20 = '0;
        d_m = NN - 1; cnt = 0; exp_valid = 1'b0; exp_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_level", 32'(level_o), 0);
        chk("rst_delay", 32'(delay_o), 31);
        chk("rst_wen", 32'(w_en), 0);
        chk("rst_ren", 32'(r_en), 0);
        chk("rst_delay20", 32'(d20_delay), 19);
        arst_n = 1'b1;
        @(negedge clk);

        // default delay, stale RAM contents must stay masked
        for (int i = 0; i < 6; i++) cyc(1, 0, 1, rnd_d(), rnd());

        // nominal delay 4 with incrementing samples
        cyc(1, 1, 0, 5'd4, '0);
        for (int i = 1; i <= 20; i++) cyc(1, 0, 1, rnd_d(), DW'(i));
        chk("nom_out", 32'(data_o), 16);

        // mid-stream restart with coincident push, new delay 2
        cyc(1, 1, 1, 5'd2, rnd());
        for (int i = 0; i < 8; i++) cyc(1, 0, 1, rnd_d(), rnd());

        // bubbles at delay 3
        cyc(1, 1, 0, 5'd3, '0);
        for (int i = 0; i < 60; i++) cyc(1, 0, 1'($urandom), rnd_d(), rnd());

        // delay 0 clamps to 1
        cyc(1, 1, 0, 5'd0, '0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 1, rnd_d(), rnd());

        // clock-enable freeze mid-stream, including a gated restart request
        cyc(1, 1, 0, 5'd5, '0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 1, rnd_d(), rnd());
        for (int i = 0; i < 5; i++) cyc(0, (i == 2), 1, rnd_d(), rnd());
        for (int i = 0; i < 10; i++) cyc(1, 0, 1, rnd_d(), rnd());

        // maximum delay with random gaps
        cyc(1, 1, 0, 5'd31, '0);
        for (int i = 0; i < 80; i++) cyc(1, 0, ($urandom_range(0, 3) != 0), rnd_d(), rnd());

        // upper clamp on the N=20 instance
        rst20 = 1'b1; dly20 = 5'd25;
        @(posedge clk); #1;
        chk("clamp20_hi", 32'(d20_delay), 19);
        dly20 = 5'd0;
        @(posedge clk); #1;
        chk("clamp20_zero", 32'(d20_delay), 1);
        dly20 = 5'd7;
        @(posedge clk); #1;
        chk("clamp20_mid", 32'(d20_delay), 7);
        rst20 = 1'b0; dly20 = 5'd12;
        @(posedge clk); #1;
        chk("clamp20_hold", 32'(d20_delay), 7);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
